// File: rtl/spi_config_controller_pkg.sv
// Shared definitions for the SPI configuration controller: command codes and FSM states.
package spi_config_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RSVD  = 2'b11
  } spi_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARB     = 2'b01,
    ST_RD_WAIT = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  // WRITE and READ are the only commands that need the SRAM port.
  function automatic logic is_access_cmd(input logic [1:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_config_controller_if.sv
// SPI-side, core-side and SRAM-side signal bundle around the configuration controller.
interface spi_config_controller_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  enable_configuration;
  logic                  write_new;
  logic                  read_sync;
  logic [1:0]            spi_cmd;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic [DATA_WIDTH-1:0] spi_wdata;

  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_gnt;
  logic                  core_rdata_valid;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [DATA_WIDTH-1:0] miso_data;
  logic                  miso_data_valid;
  logic                  busy;
  logic                  overrun_error;

  modport slave (
    input  enable_configuration, write_new, read_sync, spi_cmd, spi_addr, spi_wdata,
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rdata_valid, core_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output miso_data, miso_data_valid, busy, overrun_error
  );

  modport master (
    output enable_configuration, write_new, read_sync, spi_cmd, spi_addr, spi_wdata,
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rdata_valid, core_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  miso_data, miso_data_valid, busy, overrun_error
  );

endinterface

// File: rtl/spi_config_controller_rr_arbiter.sv
// Two-requester SRAM port arbiter; the core wins only when SPI held the previous grant.
module spi_config_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic spi_req,
  input  logic core_req,
  output logic spi_gnt,
  output logic core_gnt
);

  logic last_spi_q;
  logic last_spi_d;

  always_comb begin
    spi_gnt    = spi_req && !(last_spi_q && core_req);
    core_gnt   = core_req && !spi_gnt;
    last_spi_d = last_spi_q;
    if (spi_gnt) begin
      last_spi_d = 1'b1;
    end else if (core_gnt) begin
      last_spi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_spi_q <= 1'b0;
    end else begin
      last_spi_q <= last_spi_d;
    end
  end

endmodule

// File: rtl/spi_config_controller.sv
// Sequences SPI configuration writes/reads onto the shared SRAM port and presents
// read results on a MISO register that stays frozen while the SPI side loads it.
module spi_config_controller
  import spi_config_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  spi_config_controller_if.slave ctrl_if
);

  state_e                state_q, state_d;
  logic [1:0]            pend_cmd_q, pend_cmd_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_wdata_q, pend_wdata_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [DATA_WIDTH-1:0] miso_data_q, miso_data_d;
  logic                  miso_valid_q, miso_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  read_sync_q;
  logic                  core_rvalid_q, core_rvalid_d;

  logic                  spi_req;
  logic                  spi_gnt;
  logic                  core_gnt;
  logic                  rs_rise;
  logic                  miso_load;
  logic [DATA_WIDTH-1:0] miso_load_data;
  logic                  accept_new;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign spi_req    = (state_q == ST_ARB) && ctrl_if.enable_configuration;
  assign rs_rise    = ctrl_if.read_sync && !read_sync_q;
  assign accept_new = ctrl_if.enable_configuration && ctrl_if.write_new;

  spi_config_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .spi_req  (spi_req),
    .core_req (ctrl_if.core_req),
    .spi_gnt  (spi_gnt),
    .core_gnt (core_gnt)
  );

  always_comb begin
    state_d        = state_q;
    pend_cmd_d     = pend_cmd_q;
    pend_addr_d    = pend_addr_q;
    pend_wdata_d   = pend_wdata_q;
    hold_data_d    = hold_data_q;
    overrun_d      = overrun_q;
    miso_load      = 1'b0;
    miso_load_data = hold_data_q;

    // A new word arriving mid-operation is dropped; the running access keeps going.
    if (accept_new && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept_new) begin
          pend_cmd_d   = ctrl_if.spi_cmd;
          pend_addr_d  = ctrl_if.spi_addr;
          pend_wdata_d = ctrl_if.spi_wdata;
          if (is_access_cmd(ctrl_if.spi_cmd)) begin
            state_d = ST_ARB;
          end else if (ctrl_if.spi_cmd == CMD_RSVD) begin
            overrun_d = 1'b1;
          end
        end
      end
      ST_ARB: begin
        if (spi_gnt) begin
          state_d = (pend_cmd_q == CMD_READ) ? ST_RD_WAIT : ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (!ctrl_if.read_sync) begin
          miso_load      = 1'b1;
          miso_load_data = ctrl_if.mem_rdata;
          state_d        = ST_IDLE;
        end else begin
          hold_data_d = ctrl_if.mem_rdata;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!ctrl_if.read_sync) begin
          miso_load = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the SPI path abandons whatever was pending but keeps the last MISO result.
    if (!ctrl_if.enable_configuration) begin
      state_d    = ST_IDLE;
      pend_cmd_d = CMD_NOP;
      miso_load  = 1'b0;
    end
  end

  always_comb begin
    miso_valid_d = miso_valid_q;
    if (rs_rise) begin
      miso_valid_d = 1'b0;
    end
    if (miso_load) begin
      miso_valid_d = 1'b1;
    end
    miso_data_d   = miso_load ? miso_load_data : miso_data_q;
    core_rvalid_d = core_gnt && !ctrl_if.core_we;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (spi_gnt) begin
      mem_en    = 1'b1;
      mem_we    = (pend_cmd_q == CMD_WRITE);
      mem_addr  = pend_addr_q;
      mem_wdata = pend_wdata_q;
    end else if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ctrl_if.core_we;
      mem_addr  = ctrl_if.core_addr;
      mem_wdata = ctrl_if.core_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pend_cmd_q    <= CMD_NOP;
      miso_data_q   <= '0;
      miso_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      read_sync_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_cmd_q    <= pend_cmd_d;
      miso_data_q   <= miso_data_d;
      miso_valid_q  <= miso_valid_d;
      overrun_q     <= overrun_d;
      read_sync_q   <= ctrl_if.read_sync;
      core_rvalid_q <= core_rvalid_d;
    end
  end

  // Pure data holding registers; they are only consumed after being written.
  always_ff @(posedge clk) begin
    pend_addr_q  <= pend_addr_d;
    pend_wdata_q <= pend_wdata_d;
    hold_data_q  <= hold_data_d;
  end

  assign ctrl_if.core_gnt         = core_gnt;
  assign ctrl_if.core_rdata_valid = core_rvalid_q;
  assign ctrl_if.core_rdata       = ctrl_if.mem_rdata;
  assign ctrl_if.mem_en           = mem_en;
  assign ctrl_if.mem_we           = mem_we;
  assign ctrl_if.mem_addr         = mem_addr;
  assign ctrl_if.mem_wdata        = mem_wdata;
  assign ctrl_if.miso_data        = miso_data_q;
  assign ctrl_if.miso_data_valid  = miso_valid_q;
  assign ctrl_if.busy             = (state_q != ST_IDLE);
  assign ctrl_if.overrun_error    = overrun_q;

endmodule

// File: tb/tb_spi_config_controller.sv
// Scoreboard bench for spi_config_controller: directed scenarios plus randomized SPI/core traffic.
module tb_spi_config_controller;
  import spi_config_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  bit   core_rand_en;
  bit   exp_ovr;

  logic [15:0] ref_mem [256];
  logic [15:0] sram    [256];
  logic [15:0] spi_q   [$];
  logic [15:0] core_q  [$];

  spi_config_controller_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  spi_config_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= sram[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data whenever the DUT presents a result.
  initial begin : monitor
    logic        prev_v;
    logic        prev_rs;
    logic [15:0] prev_miso;
    logic [15:0] e;
    prev_v = 1'b0; prev_rs = 1'b0; prev_miso = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; prev_rs = 1'b0; prev_miso = bus.miso_data;
      end else begin
        if (bus.core_rdata_valid) begin
          if (core_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL core_rdata_valid: got unexpected valid, required no pending core read");
          end else begin
            e = core_q.pop_front();
            check("core_rdata", bus.core_rdata, e);
          end
        end
        if (bus.core_gnt) begin
          check("core_gnt_needs_req", bus.core_req, 1);
          check("core_mem_mux", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, bus.core_we, bus.core_addr});
          if (bus.core_we) begin
            check("core_mem_wdata", bus.mem_wdata, bus.core_wdata);
            ref_mem[bus.core_addr] = bus.core_wdata;
          end else begin
            core_q.push_back(ref_mem[bus.core_addr]);
          end
        end else if (bus.core_req) begin
          check("spi_holds_port", bus.mem_en, 1);
        end
        if (prev_rs) check("miso_stable", bus.miso_data, prev_miso);
        if (bus.miso_data_valid && !prev_v) begin
          if (spi_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL miso_unexpected: got data 0x%0h, required no pending SPI read", bus.miso_data);
          end else begin
            e = spi_q.pop_front();
            check("miso_data", bus.miso_data, e);
          end
        end
        prev_v    = bus.miso_data_valid;
        prev_rs   = bus.read_sync;
        prev_miso = bus.miso_data;
      end
    end
  end

  // Background core traffic confined to the upper half of the address space.
  initial begin : core_driver
    forever begin
      @(posedge clk); #1;
      if (core_rand_en) begin
        bus.core_req   = 1'($urandom_range(0, 1));
        bus.core_we    = 1'($urandom_range(0, 1));
        bus.core_addr  = 8'h80 | 8'($urandom_range(0, 127));
        bus.core_wdata = 16'($urandom);
      end
    end
  end

  task automatic spi_issue(input logic [1:0] cmd, input logic [7:0] a, input logic [15:0] d, input bit track);
    @(posedge clk); #1;
    bus.write_new = 1'b1;
    bus.spi_cmd   = cmd;
    bus.spi_addr  = a;
    bus.spi_wdata = d;
    if (track) begin
      case (cmd)
        CMD_WRITE: ref_mem[a] = d;
        CMD_READ:  spi_q.push_back(ref_mem[a]);
        CMD_RSVD:  exp_ovr = 1'b1;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    bus.write_new = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", bus.busy, 0);
  endtask

  task automatic consume();
    @(posedge clk); #1;
    bus.read_sync = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("valid_cleared", bus.miso_data_valid, 0);
    @(posedge clk); #1;
    bus.read_sync = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int spi_cyc;
    logic gnt_hist [1:5];
    vectors = 0; miscompares = 0; core_rand_en = 1'b0; exp_ovr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      sram[i]    = '0;
    end
    rst = 1'b1;
    bus.enable_configuration = 1'b1;
    bus.write_new = 1'b0; bus.read_sync = 1'b0;
    bus.spi_cmd = CMD_NOP; bus.spi_addr = '0; bus.spi_wdata = '0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.mem_rdata = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_miso_data", bus.miso_data, 0);
    check("rst_miso_valid", bus.miso_data_valid, 0);
    check("rst_overrun", bus.overrun_error, 0);
    check("rst_core_rvalid", bus.core_rdata_valid, 0);
    check("rst_mem_en", {bus.mem_en, bus.mem_we, bus.core_gnt}, 0);

    // Uncontended write.
    spi_issue(CMD_WRITE, 8'h12, 16'hBEEF, 1);
    @(negedge clk);
    check("wr_mem_c1", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 8'h12, 16'hBEEF});
    @(negedge clk);
    check("wr_busy_c2", bus.busy, 0);

    // Uncontended read.
    spi_issue(CMD_READ, 8'h12, 16'h0, 1);
    @(negedge clk);
    check("rd_mem_c1", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h12});
    @(negedge clk);
    check("rd_valid_c2", bus.miso_data_valid, 0);
    @(negedge clk);
    check("rd_valid_c3", {bus.miso_data_valid, bus.miso_data}, {1'b1, 16'hBEEF});
    consume();

    // Core requests continuously while SPI reads.
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h80;
    spi_issue(CMD_READ, 8'h12, 16'h0, 1);
    spi_cyc = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      gnt_hist[c] = bus.core_gnt;
      if (!bus.core_gnt && spi_cyc == 0) spi_cyc = c;
    end
    check("contend_spi_within_2", (spi_cyc >= 1 && spi_cyc <= 2), 1);
    if (spi_cyc >= 1 && spi_cyc <= 2) check("contend_core_next", gnt_hist[spi_cyc + 1], 1);
    @(posedge clk); #1;
    bus.core_req = 1'b0;
    wait_idle(8);
    check("contend_miso_valid", bus.miso_data_valid, 1);
    consume();

    // Read completes while read_sync is high: result parked until it falls.
    spi_issue(CMD_WRITE, 8'h34, 16'h1234, 1);
    wait_idle(8);
    @(posedge clk); #1;
    bus.read_sync = 1'b1;
    spi_issue(CMD_READ, 8'h34, 16'h0, 1);
    repeat (3) begin
      @(negedge clk);
      check("hold_miso_frozen", {bus.miso_data_valid, bus.miso_data}, {1'b0, 16'hBEEF});
    end
    check("hold_busy", bus.busy, 1);
    @(posedge clk); #1;
    bus.read_sync = 1'b0;
    @(negedge clk);
    check("hold_not_yet", bus.miso_data_valid, 0);
    @(negedge clk);
    check("hold_loaded", {bus.miso_data_valid, bus.miso_data, bus.busy}, {1'b1, 16'h1234, 1'b0});
    consume();

    // Second write_new one cycle after a read is dropped and flags overrun.
    spi_issue(CMD_READ, 8'h34, 16'h0, 1);
    bus.write_new = 1'b1; bus.spi_cmd = CMD_WRITE; bus.spi_addr = 8'h34; bus.spi_wdata = 16'hDEAD;
    exp_ovr = 1'b1;
    @(posedge clk); #1;
    bus.write_new = 1'b0;
    wait_idle(8);
    check("ovr_set", bus.overrun_error, 1);
    check("ovr_read_ok", bus.miso_data_valid, 1);
    consume();
    repeat (3) @(negedge clk);
    check("ovr_sticky", bus.overrun_error, 1);
    spi_issue(CMD_READ, 8'h34, 16'h0, 1);
    wait_idle(8);
    consume();

    // SPI path disabled: write_new ignored.
    bus.enable_configuration = 1'b0;
    spi_issue(CMD_WRITE, 8'h60, 16'h7777, 0);
    @(negedge clk);
    check("dis_ignored", {bus.busy, bus.mem_en}, 0);
    check("dis_miso_kept", {bus.miso_data_valid, bus.miso_data}, {1'b0, 16'h1234});
    bus.enable_configuration = 1'b1;
    spi_issue(CMD_READ, 8'h60, 16'h0, 1);
    wait_idle(8);
    consume();

    // Asynchronous reset while waiting on read data.
    spi_issue(CMD_READ, 8'h12, 16'h0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_state", {bus.busy, bus.miso_data_valid, bus.overrun_error, bus.core_rdata_valid}, 0);
    check("arst_miso_data", bus.miso_data, 0);
    check("arst_mem", {bus.mem_en, bus.mem_we, bus.core_gnt}, 0);
    exp_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    spi_issue(CMD_WRITE, 8'h56, 16'hA5A5, 1);
    @(negedge clk);
    check("arst_wr_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 8'h56, 16'hA5A5});
    wait_idle(8);
    spi_issue(CMD_READ, 8'h56, 16'h0, 1);
    wait_idle(8);
    consume();

    // Randomized SPI commands against random core traffic.
    @(negedge clk);
    core_rand_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int          r;
      int          h;
      logic [1:0]  cmd;
      logic [7:0]  a;
      logic [15:0] d;
      r   = int'($urandom_range(0, 9));
      cmd = (r == 0) ? CMD_NOP : (r == 1) ? CMD_RSVD : (r < 6) ? CMD_WRITE : CMD_READ;
      a   = 8'($urandom_range(0, 127));
      d   = 16'($urandom);
      h   = (cmd == CMD_READ) ? int'($urandom_range(0, 4)) : 0;
      if (h > 0) begin
        @(posedge clk); #1;
        bus.read_sync = 1'b1;
      end
      spi_issue(cmd, a, d, 1);
      for (int k = 0; k < h; k++) begin
        @(posedge clk); #1;
      end
      bus.read_sync = 1'b0;
      wait_idle(10);
      if (cmd == CMD_READ) begin
        check("rand_miso_valid", bus.miso_data_valid, 1);
        consume();
      end
      check("rand_overrun", bus.overrun_error, exp_ovr);
    end
    @(negedge clk);
    core_rand_en = 1'b0;
    @(posedge clk); #1;
    bus.core_req = 1'b0;
    repeat (4) @(negedge clk);
    check("spi_q_drained", spi_q.size(), 0);
    check("core_q_drained", core_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
